activation_writer: RTL
======================

ACTIVATION_WRITER -- requirements
Module: activation_writer

Interface
REQ-001 SHALL have parameter COUNT, default 8: number of W-bit elements per transfer.
REQ-002 SHALL have parameter W, default 8: element width (BRAM data width).
REQ-003 SHALL have parameter ADDR_WIDTH, default 15: BRAM address width.
REQ-004 SHALL have parameter BASE_ADDR, default 6144: BRAM address of element 0.
REQ-005 SHALL have parameter VERIFY, default 1: 1 enables the read-back compare pass.
REQ-006 SHALL have parameter READ_LAT, default 2: BRAM read latency in cycles.
REQ-007 clk  input  1  system clock; all logic on posedge clk.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 start  input  1  begin a transfer; sampled only in IDLE.
REQ-010 data_in  input  COUNT*W  flat vector; element i at data_in[i*W +: W].
REQ-011 bram_en, bram_ren, bram_wen  output  1 each  BRAM port enables.
REQ-012 bram_addr  output  ADDR_WIDTH  BRAM address.
REQ-013 bram_din  output  W  BRAM write data.
REQ-014 bram_dout  input  W  BRAM read data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at transfer end.
REQ-017 error  output  1  sticky read-back mismatch flag.
REQ-018 err_index  output  $clog2(COUNT)+1  index of first mismatching element.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE, WRITE, VERIFY, DRAIN, DONE.
REQ-021 IDLE: start=1 at edge E0 -> latch data_in into a shadow register, clear error/err_index, index:=0, go to WRITE; data_in changes after E0 have no effect.
REQ-022 WRITE: one element per cycle; bram_en=bram_wen=1, bram_ren=0, bram_addr=BASE_ADDR+i, bram_din=shadow[i], i = 0..COUNT-1 in the COUNT cycles after E0.
REQ-023 After the last write: go to VERIFY if VERIFY=1, else DONE.
REQ-024 VERIFY: bram_en=bram_ren=1, bram_wen=0; addresses BASE_ADDR+0..COUNT-1, one per cycle, COUNT cycles.
REQ-025 Read data for address k SHALL be compared with shadow[k] exactly READ_LAT cycles after that address is driven; DRAIN holds bram_en=1, bram_ren=0 for READ_LAT cycles until the last compare.
REQ-026 On mismatch: error:=1; err_index:=k only on the first mismatch of the transfer; later mismatches leave err_index unchanged.
REQ-027 DONE: done=1 for exactly one cycle, all BRAM enables 0, then IDLE.
REQ-028 done SHALL be visible in the cycle after edge E0+COUNT+1 (VERIFY=0) or E0+2*COUNT+READ_LAT+1 (VERIFY=1).
REQ-029 start while busy=1 SHALL be ignored; start held high through DONE SHALL restart a transfer from the IDLE cycle that follows.
REQ-030 Outside WRITE/VERIFY/DRAIN, bram_en, bram_ren, bram_wen SHALL be 0; bram_addr and bram_din SHALL hold their last value.
REQ-031 Address arithmetic SHALL be ADDR_WIDTH bits, no wrap; elaboration SHALL fail if BASE_ADDR+COUNT > 2**ADDR_WIDTH.
REQ-032 error and err_index SHALL hold until the next accepted start.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE and zero every output, index, and the shadow register.
REQ-034 Reset mid-transfer SHALL abort at once: no BRAM enable is asserted in the cycle after the reset edge, and done is not pulsed.
REQ-035 The first start after rst_n returns high SHALL be accepted normally.

Structure
REQ-036 State encoding and default COUNT/W/ADDR_WIDTH/READ_LAT constants SHALL live in shared package layer_mem_pkg.
REQ-037 The READ_LAT delay line and compare logic SHALL be a sub-module, bram_readback_checker; BRAM is instantiated outside this block.

Verification
REQ-038 Bench SHALL cover: VERIFY=1, data_in elements 0x01..0x08 -> writes to addresses 6144..6151, read-back clean, error=0, done at E0+19.
REQ-039 Bench SHALL cover: BRAM model corrupts address 6147 to 0xFF -> error=1, err_index=3, done still pulses.
REQ-040 Bench SHALL cover: corruption at 6145 and 6150 -> err_index=1.
REQ-041 Bench SHALL cover: VERIFY=0 -> exactly 8 write cycles, no read cycles, done at E0+9.
REQ-042 Bench SHALL cover: rst_n=0 during the 4th write -> all outputs 0 next cycle, no further enables, no done.
REQ-043 Bench SHALL cover: start pulsed during WRITE, and data_in changed after E0 -> both ignored; the BRAM contents equal the data latched at E0.

Source files
------------

// File: rtl/layer_mem_pkg.sv
// Shared constants and FSM state encoding for the layer-memory write/verify blocks.
package layer_mem_pkg;

    localparam int LM_COUNT      = 8;
    localparam int LM_W          = 8;
    localparam int LM_ADDR_WIDTH = 15;
    localparam int LM_READ_LAT   = 2;
    localparam int LM_BASE_ADDR  = 6144;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counter width that stays legal (>= 1 bit) when the range collapses to a single value.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_readback_checker.sv
// Aligns issued read indices with BRAM output data after READ_LAT cycles and records
// the first read-back mismatch of a transfer in sticky error / err_index registers.
module bram_readback_checker
    import layer_mem_pkg::*;
#(
    parameter int COUNT    = LM_COUNT,
    parameter int W        = LM_W,
    parameter int READ_LAT = LM_READ_LAT,
    parameter int IDX_W    = idx_width(LM_COUNT),
    parameter int EIW      = $clog2(LM_COUNT) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_rd_valid,
    input  logic [IDX_W-1:0]   i_rd_idx,
    input  logic [COUNT*W-1:0] i_expected,
    input  logic [W-1:0]       i_bram_dout,
    output logic               o_error,
    output logic [EIW-1:0]     o_err_index
);

    logic [READ_LAT-1:0]            r_vld_pipe;
    logic [READ_LAT-1:0][IDX_W-1:0] r_idx_pipe;
    logic                           r_error;
    logic [EIW-1:0]                 r_err_index;
    logic [IDX_W-1:0]               w_tap_idx;
    logic                           w_mismatch;

    assign w_tap_idx  = r_idx_pipe[READ_LAT-1];
    assign w_mismatch = r_vld_pipe[READ_LAT-1] &&
                        (i_bram_dout != i_expected[int'(w_tap_idx)*W +: W]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_idx_pipe  <= '0;
            r_error     <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_vld_pipe[0] <= i_rd_valid;
            r_idx_pipe[0] <= i_rd_idx;
            // NOTE: non-blocking assignments make every stage read its neighbour's old value,
            // so the shift is correct regardless of loop order.
            for (int s = 1; s < READ_LAT; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_idx_pipe[s] <= r_idx_pipe[s-1];
            end
            if (i_clear) begin
                r_error     <= 1'b0;
                r_err_index <= '0;
            end else if (w_mismatch) begin
                r_error <= 1'b1;
                if (!r_error) begin
                    r_err_index <= EIW'(w_tap_idx);
                end
            end
        end
    end

    assign o_error     = r_error;
    assign o_err_index = r_err_index;

endmodule

// File: rtl/activation_writer.sv
// Writes a latched COUNT-element activation vector into BRAM, optionally reads it back
// and compares, then pulses done. Every output is registered and lags the FSM by one cycle.
module activation_writer
    import layer_mem_pkg::*;
#(
    parameter int COUNT      = LM_COUNT,
    parameter int W          = LM_W,
    parameter int ADDR_WIDTH = LM_ADDR_WIDTH,
    parameter int BASE_ADDR  = LM_BASE_ADDR,
    parameter int VERIFY     = 1,
    parameter int READ_LAT   = LM_READ_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COUNT*W-1:0]      data_in,
    output logic                    bram_en,
    output logic                    bram_ren,
    output logic                    bram_wen,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [W-1:0]            bram_din,
    input  logic [W-1:0]            bram_dout,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [$clog2(COUNT):0]  err_index
);

    localparam int IDX_W = idx_width(COUNT);
    localparam int EIW   = $clog2(COUNT) + 1;
    localparam int DRN_W = idx_width(READ_LAT);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(COUNT - 1);
    localparam logic [DRN_W-1:0]      LAST_DRN = DRN_W'(READ_LAT - 1);

    if (longint'(BASE_ADDR) + longint'(COUNT) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_range_bad
        $error("activation_writer: BASE_ADDR+COUNT exceeds the BRAM address space");
    end
    if (READ_LAT < 1 || COUNT < 1) begin : g_param_bad
        $error("activation_writer: COUNT and READ_LAT must be at least 1");
    end

    state_e               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DRN_W-1:0]     r_drn, w_drn_nxt;
    logic                 w_accept;
    logic [COUNT*W-1:0]   r_shadow;
    logic [IDX_W-1:0]     r_rd_idx;
    logic                 r_bram_en, r_bram_ren, r_bram_wen, r_busy, r_done;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [W-1:0]         r_bram_din;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_drn_nxt   = r_drn;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WRITE;
                    w_idx_nxt   = '0;
                end
            end
            ST_WRITE: begin
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_VERIFY: begin
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt   = '0;
                    w_drn_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drn == LAST_DRN) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drn_nxt = r_drn + 1'b1;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_drn    <= '0;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_drn   <= w_drn_nxt;
            if (w_accept) begin
                r_shadow <= data_in;
            end
        end
    end

    // Port outputs follow the state of the previous cycle; address/data hold outside WRITE/VERIFY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bram_en   <= 1'b0;
            r_bram_ren  <= 1'b0;
            r_bram_wen  <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_rd_idx    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bram_en  <= (r_state == ST_WRITE) || (r_state == ST_VERIFY) || (r_state == ST_DRAIN);
            r_bram_wen <= (r_state == ST_WRITE);
            r_bram_ren <= (r_state == ST_VERIFY);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (r_state == ST_DONE);
            if (r_state == ST_WRITE || r_state == ST_VERIFY) begin
                r_bram_addr <= BASE + ADDR_WIDTH'(r_idx);
            end
            if (r_state == ST_WRITE) begin
                r_bram_din <= r_shadow[int'(r_idx)*W +: W];
            end
            if (r_state == ST_VERIFY) begin
                r_rd_idx <= r_idx;
            end
        end
    end

    bram_readback_checker #(
        .COUNT    (COUNT),
        .W        (W),
        .READ_LAT (READ_LAT),
        .IDX_W    (IDX_W),
        .EIW      (EIW)
    ) u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept),
        .i_rd_valid  (r_bram_ren),
        .i_rd_idx    (r_rd_idx),
        .i_expected  (r_shadow),
        .i_bram_dout (bram_dout),
        .o_error     (error),
        .o_err_index (err_index)
    );

    assign bram_en   = r_bram_en;
    assign bram_ren  = r_bram_ren;
    assign bram_wen  = r_bram_wen;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
